// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: KSA + PRGA over the shared 256x8 s_memory, ciphertext bytes go to an external RAM.
// Latency: done rises 2049+11*MSG_LEN cycles after start is accepted. No backpressure: RAM ports are always ready.
// Optional RC4_ENC_KEY22_EN: clears secret_key[23:22] when the key is latched.
module rc4_encrypt_core #(
    parameter int MSG_LEN = 32
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [23:0]             secret_key,
    input  logic [MSG_LEN-1:0][7:0] plain_data,
    output logic [7:0]              s_mem_address,
    output logic [7:0]              s_mem_data,
    output logic                    s_mem_wren,
    input  logic [7:0]              s_mem_q,
    output logic [4:0]              ct_address,
    output logic [7:0]              ct_data,
    output logic                    ct_wren,
    output logic                    busy,
    output logic                    done
);

    localparam int KW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [4:0] {
        S_IDLE,
        S_INIT,
        K_ADDR_I,
        K_WAIT_I,
        K_READ_I,
        K_ADDR_J,
        K_WAIT_J,
        K_WR_I,
        K_WR_J,
        P_INC,
        P_ADDR_I,
        P_WAIT_I,
        P_READ_I,
        P_ADDR_J,
        P_WAIT_J,
        P_WR_I,
        P_WR_J,
        P_ADDR_F,
        P_WAIT_F,
        P_OUT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [7:0]              i;
    logic [7:0]              j;
    logic [4:0]              k;
    logic [7:0]              si;
    logic [7:0]              sj;
    logic [1:0]              kmod;
    logic [23:0]             key_r;
    logic [MSG_LEN-1:0][7:0] plain_r;
    logic [7:0]              key_byte;
    logic                    last_byte;
    logic                    accept;

    assign accept    = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign last_byte = (k == 5'(MSG_LEN - 1));

    // kmod tracks i mod 3 so the key byte is selected without a divider
    always_comb begin
        key_byte = key_r[23:16];
        case (kmod)
            2'd1:    key_byte = key_r[15:8];
            2'd2:    key_byte = key_r[7:0];
            default: key_byte = key_r[23:16];
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_INIT;
            S_INIT:   if (i == 8'hFF) state_n = K_ADDR_I;
            K_ADDR_I: state_n = K_WAIT_I;
            K_WAIT_I: state_n = K_READ_I;
            K_READ_I: state_n = K_ADDR_J;
            K_ADDR_J: state_n = K_WAIT_J;
            K_WAIT_J: state_n = K_WR_I;
            K_WR_I:   state_n = K_WR_J;
            K_WR_J:   state_n = (i == 8'hFF) ? P_INC : K_ADDR_I;
            P_INC:    state_n = P_ADDR_I;
            P_ADDR_I: state_n = P_WAIT_I;
            P_WAIT_I: state_n = P_READ_I;
            P_READ_I: state_n = P_ADDR_J;
            P_ADDR_J: state_n = P_WAIT_J;
            P_WAIT_J: state_n = P_WR_I;
            P_WR_I:   state_n = P_WR_J;
            P_WR_J:   state_n = P_ADDR_F;
            P_ADDR_F: state_n = P_WAIT_F;
            P_WAIT_F: state_n = P_OUT;
            P_OUT:    state_n = last_byte ? S_DONE : P_INC;
            S_DONE:   if (start) state_n = S_INIT;
            default:  state_n = S_IDLE;
        endcase
    end

    // Addresses stay put through the wait and read states so the 1-cycle RAM sees a stable address
    always_comb begin
        s_mem_address = i;
        s_mem_data    = 8'h00;
        s_mem_wren    = 1'b0;
        ct_address    = 5'd0;
        ct_data       = 8'h00;
        ct_wren       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                s_mem_address = 8'h00;
            end
            S_INIT: begin
                s_mem_data = i;
                s_mem_wren = 1'b1;
            end
            K_ADDR_J, K_WAIT_J, P_ADDR_J, P_WAIT_J: begin
                s_mem_address = j;
            end
            K_WR_I, P_WR_I: begin
                s_mem_data = s_mem_q;
                s_mem_wren = 1'b1;
            end
            K_WR_J, P_WR_J: begin
                s_mem_address = j;
                s_mem_data    = si;
                s_mem_wren    = 1'b1;
            end
            P_ADDR_F, P_WAIT_F: begin
                s_mem_address = si + sj;
            end
            P_OUT: begin
                s_mem_address = si + sj;
                ct_address    = k;
                ct_data       = s_mem_q ^ plain_r[k[KW-1:0]];
                ct_wren       = 1'b1;
            end
            default: begin
                s_mem_address = i;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            i       <= 8'h00;
            j       <= 8'h00;
            k       <= 5'd0;
            si      <= 8'h00;
            sj      <= 8'h00;
            kmod    <= 2'd0;
            key_r   <= 24'h000000;
            plain_r <= '0;
        end else begin
            if (accept) begin
`ifdef RC4_ENC_KEY22_EN
                key_r <= {2'b00, secret_key[21:0]};
`else
                key_r <= secret_key;
`endif
                plain_r <= plain_data;
                i       <= 8'h00;
                j       <= 8'h00;
                k       <= 5'd0;
                kmod    <= 2'd0;
            end
            case (state)
                S_INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) j <= 8'h00;
                end
                K_READ_I: begin
                    si <= s_mem_q;
                    j  <= j + s_mem_q + key_byte;
                end
                K_WR_I: sj <= s_mem_q;
                K_WR_J: begin
                    i    <= i + 8'd1;
                    kmod <= (kmod == 2'd2) ? 2'd0 : kmod + 2'd1;
                    if (i == 8'hFF) j <= 8'h00;
                end
                P_INC: i <= i + 8'd1;
                P_READ_I: begin
                    si <= s_mem_q;
                    j  <= j + s_mem_q;
                end
                P_WR_I: sj <= s_mem_q;
                P_OUT:  k  <= k + 5'd1;
                default: begin
                end
            endcase
        end
    end

    // Status flags follow the FSM by one cycle: done rises the cycle after the last ciphertext byte
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
            done <= 1'b0;
        end else if (state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

endmodule
